// File: rtl/opb_register_ppc2simulink.sv
// ---------------------------------------------------------------------------
// opb_register_ppc2simulink
//
// OPB slave holding one 32-bit register that the PowerPC writes and the user
// fabric consumes. It also holds a 32-bit write counter that counts register
// updates.
//
// Address map, relative to C_BASEADDR:
//    0x0  data register (write; reads back only with the readback build)
//    0x4  write counter (read-only; reads back only with the readback build)
//    any other offset inside [C_BASEADDR, C_HIGHADDR] is acked, reads 0 and
//    ignores writes.
//
// Optional feature macro: OPB_PPC2SIM_READBACK_EN
//    defined   : reads of 0x0 return the register, reads of 0x4 the counter.
//    undefined : every read is acked with Sl_DBus = 0. The write path and the
//                counter behave the same in both builds.
//
// Ports:
//    OPB_Clk           sole clock, rising edge
//    OPB_Rst_n         asynchronous active-low reset
//    OPB_ABus[0:31]    byte address (bit 0 = MSB)
//    OPB_BE[0:3]       byte enables, BE[0] covers DBus[0:7]
//    OPB_DBus[0:31]    write data (bit 0 = MSB)
//    OPB_RNW           1 = read, 0 = write
//    OPB_select        transfer request
//    OPB_seqAddr       ignored
//    Sl_DBus[0:31]     read data, zero outside a read acknowledge
//    Sl_xferAck        transfer acknowledge
//    Sl_errAck, Sl_retry, Sl_toutSup   tied low
//    user_data_out     register value; user bit 31 = OPB bit 0
//    user_data_strobe  one-cycle pulse when user_data_out changes
//
// Timing: select sampled in cycle N, ack in N+1, user_data_out/strobe in N+2.
// After every ack the slave spends one GAP cycle, so acks are at least three
// cycles apart even if the master keeps select asserted.
// ---------------------------------------------------------------------------
module opb_register_ppc2simulink #(
   parameter logic [31:0] C_BASEADDR   = 32'h01000600,
   parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   output logic [C_OPB_DWIDTH-1:0]     user_data_out,
   output logic                        user_data_strobe
);

   localparam int NB = C_OPB_DWIDTH / 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // The family string only selects device primitives in the original core;
   // nothing in this implementation depends on it.
   localparam string unused_family = C_FAMILY;

   // Merge write data into the old register value, byte lane by byte lane.
   // be[j] guards user bits [8j+7:8j]; be[NB-1] is OPB BE[0] (the MSB lane).
   function automatic logic [C_OPB_DWIDTH-1:0] merge_lanes(
      input logic [C_OPB_DWIDTH-1:0] old_val,
      input logic [C_OPB_DWIDTH-1:0] wr_val,
      input logic [NB-1:0]           be
   );
      logic [C_OPB_DWIDTH-1:0] res;
      res = old_val;
      for (int j = 0; j < NB; j++) begin
         if (be[j]) begin
            res[8*j +: 8] = wr_val[8*j +: 8];
         end else begin
            res[8*j +: 8] = old_val[8*j +: 8];
         end
      end
      return res;
   endfunction

   // State and datapath flops.
   logic [1:0]              state_q;
   logic [1:0]              state_d;
   logic [C_OPB_DWIDTH-1:0] data_q;
   logic [C_OPB_DWIDTH-1:0] data_d;
   logic [31:0]             count_q;
   logic [31:0]             count_d;
   logic                    strobe_q;
   logic                    strobe_d;

   // Bus decode, converted to descending little-endian-numbered vectors so
   // that user bit 31 lines up with OPB bit 0 by plain assignment.
   logic [C_OPB_AWIDTH-1:0] addr_s;
   logic [C_OPB_AWIDTH-1:0] offset_s;
   logic [NB-1:0]           be_s;
   logic [C_OPB_DWIDTH-1:0] wr_data_s;
   logic [C_OPB_DWIDTH-1:0] rd_data_s;
   logic                    hit_s;
   logic                    reg_sel_s;
   logic                    cnt_sel_s;
   logic                    ack_s;
   logic                    wr_s;
   logic                    unused_s;

   assign addr_s    = OPB_ABus;
   assign be_s      = OPB_BE;
   assign wr_data_s = OPB_DBus;
   assign unused_s  = OPB_seqAddr;

   assign hit_s     = (addr_s >= C_BASEADDR) && (addr_s <= C_HIGHADDR);
   assign offset_s  = addr_s - C_BASEADDR;
   assign reg_sel_s = hit_s && (offset_s == 32'h0000_0000);
   assign cnt_sel_s = hit_s && (offset_s == 32'h0000_0004);

   // The ack is gated by the live select, so a master that withdraws select
   // in the ACK cycle gets neither an ack nor a committed write.
   assign ack_s = (state_q == ST_ACK) && OPB_select;
   assign wr_s  = ack_s && !OPB_RNW;

   // Next-state logic of the IDLE -> ACK -> GAP handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (OPB_select && hit_s) begin
               state_d = ST_ACK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK:  state_d = ST_GAP;
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Register, strobe and counter updates; only a real write ack to offset 0
   // with at least one byte enable counts as an update.
   always_comb begin
      data_d   = data_q;
      strobe_d = 1'b0;
      count_d  = count_q;
      if (wr_s && reg_sel_s) begin
         data_d   = merge_lanes(data_q, wr_data_s, be_s);
         strobe_d = |be_s;
      end else begin
         data_d   = data_q;
         strobe_d = 1'b0;
      end
      if (strobe_d) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Read mux; reads sample the flops, i.e. the value before any update
   // landing on the same edge.
   always_comb begin
      rd_data_s = '0;
`ifdef OPB_PPC2SIM_READBACK_EN
      if (reg_sel_s) begin
         rd_data_s = data_q;
      end else if (cnt_sel_s) begin
         rd_data_s = count_q;
      end else begin
         rd_data_s = '0;
      end
`else
      if (cnt_sel_s || reg_sel_s) begin
         rd_data_s = '0;
      end else begin
         rd_data_s = '0;
      end
`endif
   end

   // Sequential state: FSM, register, strobe and write counter.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         strobe_q <= 1'b0;
         count_q  <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         count_q  <= count_d;
      end
   end

   // Bus outputs: read data only while a read is being acknowledged.
   assign Sl_xferAck = ack_s;
   assign Sl_DBus    = (ack_s && OPB_RNW) ? rd_data_s : '0;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign user_data_out    = data_q;
   assign user_data_strobe = strobe_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
module tb_opb_register_ppc2simulink;

   localparam logic [31:0] BASE = 32'h01000600;
   localparam logic [31:0] HIGH = 32'h010006FF;

   logic        clk;
   logic        rst_n;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus;
   logic        rnw;
   logic        sel;
   logic        seq_addr;
   logic [0:31] sl_dbus;
   logic        sl_ack;
   logic        sl_err;
   logic        sl_retry;
   logic        sl_tout;
   logic [31:0] ud_out;
   logic        ud_stb;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] model_reg;
   logic [31:0] model_cnt;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] ud;
      logic        stb;
   } exp_t;
   exp_t sb_q[$];

   opb_register_ppc2simulink dut (
      .OPB_Clk          (clk),
      .OPB_Rst_n        (rst_n),
      .OPB_ABus         (abus),
      .OPB_BE           (be),
      .OPB_DBus         (dbus),
      .OPB_RNW          (rnw),
      .OPB_select       (sel),
      .OPB_seqAddr      (seq_addr),
      .Sl_DBus          (sl_dbus),
      .Sl_xferAck       (sl_ack),
      .Sl_errAck        (sl_err),
      .Sl_retry         (sl_retry),
      .Sl_toutSup       (sl_tout),
      .user_data_out    (ud_out),
      .user_data_strobe (ud_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Full OPB transfer at a hit address: push expectation, wait for the ack
   // with a bounded budget, then check latency, read data and the update.
   task automatic do_xfer(input logic [31:0] addr, input logic r, input logic [3:0] b,
                          input logic [31:0] d, input string name);
      exp_t        e;
      logic [31:0] off;
      int          cyc;
      off   = addr - BASE;
      e.rd  = 32'h0;
      e.stb = 1'b0;
      if (r) begin
`ifdef OPB_PPC2SIM_READBACK_EN
         if (off == 32'h0) e.rd = model_reg;
         else if (off == 32'h4) e.rd = model_cnt;
`endif
      end else if (off == 32'h0) begin
         for (int j = 0; j < 4; j++) begin
            if (b[j]) model_reg[8*j +: 8] = d[8*j +: 8];
         end
         if (b != 4'b0000) begin
            e.stb     = 1'b1;
            model_cnt = model_cnt + 32'd1;
         end
      end
      e.ud = model_reg;
      sb_q.push_back(e);

      @(negedge clk);
      abus = addr; rnw = r; be = b; dbus = d; sel = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!sl_ack && cyc < 6);
      e = sb_q.pop_front();

      n_checks++;
      if (sl_ack !== 1'b1 || cyc != 1) begin
         n_errors++;
         $display("FAIL %s ack_latency: ack=%b after %0d cycles, required ack=1 after 1", name, sl_ack, cyc);
      end
      n_checks++;
      if (sl_dbus !== e.rd) begin
         n_errors++;
         $display("FAIL %s rd_data: got %h, required %h", name, sl_dbus, e.rd);
      end

      @(posedge clk); #1;
      sel = 1'b0; rnw = 1'b0; dbus = 32'h0; be = 4'b0000;
      #1;
      n_checks++;
      if (ud_out !== e.ud || ud_stb !== e.stb) begin
         n_errors++;
         $display("FAIL %s update: user_data=%h strobe=%b, required %h/%b", name, ud_out, ud_stb, e.ud, e.stb);
      end
      n_checks++;
      if (sl_ack !== 1'b0 || sl_dbus !== 32'h0) begin
         n_errors++;
         $display("FAIL %s post_ack_idle: ack=%b dbus=%h, required 0/0", name, sl_ack, sl_dbus);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ud_stb !== 1'b0) begin
         n_errors++;
         $display("FAIL %s strobe_width: strobe=%b in second cycle, required 0", name, ud_stb);
      end
   endtask

   // Transfer that must never be acked (miss address).
   task automatic expect_no_ack(input logic [31:0] addr, input logic r, input string name);
      int acks;
      acks = 0;
      @(negedge clk);
      abus = addr; rnw = r; be = 4'b1111; dbus = 32'hA5A5A5A5; sel = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (sl_ack === 1'b1 || sl_dbus !== 32'h0 || ud_stb !== 1'b0) acks++;
      end
      sel = 1'b0; dbus = 32'h0;
      n_checks++;
      if (acks != 0 || ud_out !== model_reg) begin
         n_errors++;
         $display("FAIL %s no_ack: %0d active cycles, user_data=%h, required 0 cycles and %h",
                  name, acks, ud_out, model_reg);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sel = 1'b0; abus = BASE; be = 4'b1111; dbus = 32'hFFFFFFFF;
      rnw = 1'b0; seq_addr = 1'b0;
      model_reg = 32'h0; model_cnt = 32'h0;
      // select held high during reset must not start anything
      sel = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (sl_ack !== 1'b0 || sl_dbus !== 32'h0 || ud_out !== 32'h0 || ud_stb !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: ack=%b dbus=%h ud=%h stb=%b, required all 0", sl_ack, sl_dbus, ud_out, ud_stb);
      end
      n_checks++;
      if (sl_err !== 1'b0 || sl_retry !== 1'b0 || sl_tout !== 1'b0) begin
         n_errors++;
         $display("FAIL tied_outputs: err=%b retry=%b tout=%b, required 0", sl_err, sl_retry, sl_tout);
      end
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (ud_out !== 32'h0 || sl_ack !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: ud=%h ack=%b, required 0/0", ud_out, sl_ack);
      end
   endtask

   task automatic test_full_write();
      do_xfer(BASE, 1'b0, 4'b1111, 32'hDEADBEEF, "full_write");
      n_checks++;
      if (ud_out !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL full_write_value: got %h, required DEADBEEF", ud_out);
      end
   endtask

   task automatic test_byte_lanes();
      do_xfer(BASE, 1'b0, 4'b0101, 32'h11223344, "be_0101");
      n_checks++;
      if (ud_out !== 32'hDE22BE44) begin
         n_errors++;
         $display("FAIL be_0101_value: got %h, required DE22BE44", ud_out);
      end
      do_xfer(BASE, 1'b0, 4'b1000, 32'h99000000, "be_1000");
      do_xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF, "be_0000");
      do_xfer(BASE, 1'b0, 4'b1111, 32'h11223344, "full_write_2");
   endtask

   task automatic test_read();
      do_xfer(BASE,         1'b1, 4'b1111, 32'h0, "read_reg");
      do_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0, "read_cnt");
      n_checks++;
      if (model_cnt !== 32'd4 || ud_out !== 32'h11223344) begin
         n_errors++;
         $display("FAIL read_no_side_effect: ud=%h, required 11223344 (model count %0d, required 4)",
                  ud_out, model_cnt);
      end
   endtask

   task automatic test_other_offsets();
      do_xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h12345678, "write_cnt_ro");
      do_xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'hCAFEBABE, "write_off8");
      do_xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0,        "read_off8");
      do_xfer(HIGH,         1'b0, 4'b1111, 32'h0BADF00D, "write_high");
      do_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0,        "read_cnt_2");
   endtask

   // Select held for 10 cycles: acks expected in cycles 1, 4 and 7 only;
   // the ACK state reached at cycle 10 sees select withdrawn.
   task automatic test_back_to_back();
      int acks;
      logic exp_ack;
      acks = 0;
      @(negedge clk);
      abus = BASE + 32'h8; rnw = 1'b0; be = 4'b1111; dbus = 32'hFFFF0000; sel = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 10) begin
            sel = 1'b0;
            #1;
         end
         exp_ack = (c == 1) || (c == 4) || (c == 7);
         if (sl_ack === 1'b1) acks++;
         n_checks++;
         if (sl_ack !== exp_ack || sl_dbus !== 32'h0 || ud_stb !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_cycle%0d: ack=%b dbus=%h stb=%b, required %b/0/0", c, sl_ack, sl_dbus, ud_stb, exp_ack);
         end
      end
      n_checks++;
      if (acks != 3 || ud_out !== model_reg) begin
         n_errors++;
         $display("FAIL b2b_total: %0d acks ud=%h, required 3 and %h", acks, ud_out, model_reg);
      end
      repeat (3) @(posedge clk);
   endtask

   // Select withdrawn in the ACK cycle: no ack, no write.
   task automatic test_abort();
      @(negedge clk);
      abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'h55AA55AA; sel = 1'b1;
      @(posedge clk); #1;
      sel = 1'b0;
      #1;
      n_checks++;
      if (sl_ack !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_ack: ack=%b, required 0", sl_ack);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (ud_out !== model_reg || ud_stb !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_write: ud=%h stb=%b, required %h/0", ud_out, ud_stb, model_reg);
      end
      repeat (2) @(posedge clk);
   endtask

   // Reset hits in the ACK cycle; the pending ack and write vanish.
   task automatic test_reset_mid();
      @(negedge clk);
      abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFEF00D; sel = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      model_reg = 32'h0;
      model_cnt = 32'h0;
      n_checks++;
      if (sl_ack !== 1'b0 || ud_out !== 32'h0 || ud_stb !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid: ack=%b ud=%h stb=%b, required 0/0/0", sl_ack, ud_out, ud_stb);
      end
      @(posedge clk); #1;
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (ud_out !== 32'h0 || ud_stb !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_after: ud=%h stb=%b, required 0/0", ud_out, ud_stb);
      end
      do_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0, "read_cnt_after_reset");
      do_xfer(BASE, 1'b0, 4'b0011, 32'h0000ABCD, "write_after_reset");
   endtask

   task automatic test_miss();
      expect_no_ack(HIGH + 32'h1, 1'b0, "miss_high_plus1");
      expect_no_ack(BASE - 32'h1, 1'b1, "miss_base_minus1");
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_full_write();
      test_byte_lanes();
      test_read();
      test_other_offsets();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_miss();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
